// File: rtl/bcd_counter_multi_if.sv
// Control and result bundle of the multi-digit BCD counter.
// There is no valid/ready handshake here. The master drives en, up_down, load and load_val,
// and the counter samples them on every rising clk edge. The slave presents bcd and wrap,
// which are both registered and change only on a clk edge or on reset.
interface bcd_counter_multi_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up_down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd;
  logic                  wrap;

  modport master (
    output en,
    output up_down,
    output load,
    output load_val,
    input  bcd,
    input  wrap
  );

  modport slave (
    input  en,
    input  up_down,
    input  load,
    input  load_val,
    output bcd,
    output wrap
  );
endinterface

// File: rtl/bcd_counter_multi.sv
// Parametrised multi-digit BCD up/down counter with parallel load and a wrap pulse.
// Digit 0 is the least significant and sits in bits [3:0]. Each edge performs one step
// across all digits, using a single combinational carry/borrow chain.
module bcd_counter_multi #(
  parameter int DIGITS = 4
) (
  input logic              clk,
  input logic              rst,
  bcd_counter_multi_if.slave bus
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] bcd_q;
  logic [W-1:0] bcd_next;
  logic         wrap_q;
  logic         wrap_next;
  logic         chain;
  logic [3:0]   cur;

  // Loaded digits above 9 saturate to 9, so an illegal digit never enters the register.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Increment a digit from 9 back to 0. Values of 9 or more are treated as 9.
  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Decrement a digit from 0 up to 9. Illegal values fall back to 9.
  function automatic logic [3:0] dec_digit(input logic [3:0] d);
    logic [3:0] r;
    if (d == 4'd0 || d > 4'd9) begin
      r = 4'd9;
    end else begin
      r = d - 4'd1;
    end
    return r;
  endfunction

  // Next-state logic. Priority is load, then count, then hold.
  // While counting, chain is high when every lower digit sits at its terminal value
  // (9 going up, 0 going down). A chain still high past the top digit means a wrap.
  always_comb begin
    bcd_next  = bcd_q;
    wrap_next = 1'b0;
    chain     = 1'b1;
    cur       = 4'd0;
    if (bus.load) begin
      for (int i = 0; i < DIGITS; i++) begin
        bcd_next[4*i +: 4] = clamp_digit(bus.load_val[4*i +: 4]);
      end
    end else if (bus.en) begin
      for (int i = 0; i < DIGITS; i++) begin
        cur = bcd_q[4*i +: 4];
        if (chain) begin
          bcd_next[4*i +: 4] = bus.up_down ? inc_digit(cur) : dec_digit(cur);
        end
        chain = chain & (bus.up_down ? (cur == 4'd9) : (cur == 4'd0));
      end
      wrap_next = chain;
    end
  end

  // Count and wrap registers. Reset clears both immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_next;
      wrap_q <= wrap_next;
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.wrap = wrap_q;

endmodule
